// File: rtl/dbuf_page_reader.sv
// Reader engine for the mDOM readout double buffer: fetches one page from the selected DPRAM half,
// streams it out with backpressure and releases the half. Optional counters: DBUF_PAGE_READER_STATS_EN.
module dbuf_page_reader #(
    parameter int P_RD_ADDR_WIDTH = 9,
    parameter int P_RD_DATA_WIDTH = 64,
    parameter int P_RD_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       buf_rd_busy,
    input  logic [15:0]                buf_len,
    output logic [P_RD_ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [P_RD_DATA_WIDTH-1:0] buf_rd_dout,
    output logic                       buf_done,
    output logic [P_RD_DATA_WIDTH-1:0] dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic [15:0]                pages_read,
    output logic [31:0]                words_read
);

    localparam int AW        = P_RD_ADDR_WIDTH;
    localparam int DW        = P_RD_DATA_WIDTH;
    localparam int LAT       = P_RD_LATENCY;
    localparam int N_W       = AW + 1;
    localparam int MEM_DEPTH = LAT + 1;
    localparam int PTR_W     = $clog2(MEM_DEPTH);
    localparam int MEM_SIZE  = 1 << PTR_W;
    localparam int CNT_W     = 4;

    localparam logic [CNT_W-1:0] CREDIT_LIMIT = CNT_W'(LAT + 2);
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(MEM_DEPTH - 1);
    localparam logic [31:0]      MAX_LEN      = 32'd1 << AW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4,
        S_GUARD   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [N_W-1:0]   n_q, n_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LAT-1:0]   vpipe_q, vpipe_d;
    logic [LAT-1:0]   lpipe_q, lpipe_d;
    logic [DW-1:0]    mem_q [MEM_SIZE];
    logic [DW-1:0]    mem_d [MEM_SIZE];
    logic [MEM_SIZE-1:0] mem_last_q, mem_last_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             buf_done_q, buf_done_d;

    logic             pop_s;
    logic             wr_s;
    logic             wr_last_s;
    logic             out_free_s;
    logic             push_s;
    logic             mpop_s;
    logic [CNT_W-1:0] inflight_s;
    logic [CNT_W-1:0] occ_s;
    logic             credit_ok_s;
    logic             issue_s;
    logic             last_issue_s;
    logic             addr_is_last_s;
    logic [31:0]      len_ext_s;
    logic [N_W-1:0]   eff_len_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Credit accounting: reads in flight plus FIFO words that survive this cycle's pop.
    always_comb begin
        pop_s      = dout_valid_q & dout_ready;
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + {{(CNT_W-1){1'b0}}, vpipe_q[i]};
        end
        occ_s       = mem_cnt_q + {{(CNT_W-1){1'b0}}, dout_valid_q} - {{(CNT_W-1){1'b0}}, pop_s};
        credit_ok_s = (inflight_s + occ_s) < CREDIT_LIMIT;
    end

    // Return path: valid/last tag pipe and show-ahead FIFO whose head is the output register.
    always_comb begin
        wr_s       = vpipe_q[LAT-1];
        wr_last_s  = lpipe_q[LAT-1];
        out_free_s = ~dout_valid_q | pop_s;

        vpipe_d[0] = issue_s;
        lpipe_d[0] = last_issue_s;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end

        mem_d        = mem_q;
        mem_last_d   = mem_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_cnt_d    = mem_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        push_s       = 1'b0;
        mpop_s       = 1'b0;

        if (out_free_s) begin
            if (mem_cnt_q != {CNT_W{1'b0}}) begin
                dout_d       = mem_q[rd_ptr_q];
                dout_last_d  = mem_last_q[rd_ptr_q];
                dout_valid_d = 1'b1;
                mpop_s       = 1'b1;
                push_s       = wr_s;
            end else if (wr_s) begin
                // Empty storage: returned word bypasses straight into the output register.
                dout_d       = buf_rd_dout;
                dout_last_d  = wr_last_s;
                dout_valid_d = 1'b1;
            end else begin
                dout_valid_d = 1'b0;
                dout_last_d  = 1'b0;
            end
        end else begin
            push_s = wr_s;
        end

        if (push_s) begin
            mem_d[wr_ptr_q]      = buf_rd_dout;
            mem_last_d[wr_ptr_q] = wr_last_s;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (mpop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, mpop_s})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1'b1);
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1'b1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    // Page FSM: length capture, address issue, drain, release handshake.
    always_comb begin
        len_ext_s      = {16'h0000, buf_len};
        eff_len_s      = (len_ext_s > MAX_LEN) ? N_W'(MAX_LEN) : N_W'(len_ext_s);
        addr_is_last_s = (N_W'(addr_q) + N_W'(1'b1)) == n_q;

        state_d      = state_q;
        n_d          = n_q;
        addr_d       = addr_q;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_d = {AW{1'b0}};
                if (buf_rd_busy) begin
                    n_d = eff_len_s;
                    if (eff_len_s == {N_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (addr_is_last_s) begin
                        last_issue_s = 1'b1;
                        state_d      = S_DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1'b1);
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) && pop_s && dout_last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!buf_rd_busy) begin
                    state_d = S_GUARD;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_GUARD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        buf_done_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset flushes the pipe and FIFO mid-page.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= {N_W{1'b0}};
            addr_q       <= {AW{1'b0}};
            vpipe_q      <= {LAT{1'b0}};
            lpipe_q      <= {LAT{1'b0}};
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            mem_last_q   <= {MEM_SIZE{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            mem_cnt_q    <= {CNT_W{1'b0}};
            dout_q       <= {DW{1'b0}};
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            buf_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            vpipe_q      <= vpipe_d;
            lpipe_q      <= lpipe_d;
            mem_q        <= mem_d;
            mem_last_q   <= mem_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            buf_done_q   <= buf_done_d;
        end
    end

    assign buf_rd_addr = addr_q;
    assign buf_done    = buf_done_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_last   = dout_last_q;

`ifdef DBUF_PAGE_READER_STATS_EN
    logic [15:0] pages_q, pages_d;
    logic [31:0] words_q, words_d;

    // Page counter wraps; word counter saturates.
    always_comb begin
        if (buf_done_q) begin
            pages_d = pages_q + 16'd1;
        end else begin
            pages_d = pages_q;
        end
        if (pop_s && (words_q != 32'hFFFF_FFFF)) begin
            words_d = words_q + 32'd1;
        end else begin
            words_d = words_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pages_q <= 16'd0;
            words_q <= 32'd0;
        end else begin
            pages_q <= pages_d;
            words_q <= words_d;
        end
    end

    assign pages_read = pages_q;
    assign words_read = words_q;
`else
    assign pages_read = 16'd0;
    assign words_read = 32'd0;
`endif

endmodule

// File: doc/dbuf_page_reader.md
# dbuf_page_reader

Reader-side engine for the mDOM readout double buffer. It waits for the buffer's read-side busy flag and fetches `dpram_len` words from the read port of the currently selected DPRAM half. It streams those words out on a valid/ready interface with backpressure, then returns the half to the writer with a single-cycle `done` pulse. It sits between the double buffer's reader interface and the downstream packer or shipper.

## Interface
Parameters:
- `P_RD_ADDR_WIDTH`, 9: read address width of one buffer half.
- `P_RD_DATA_WIDTH`, 64: read word width.
- `P_RD_LATENCY`, 2: fixed DPRAM read latency in cycles, from address to data; allowed range 1–4.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `buf_rd_busy`  in  1: selected half holds a complete page.
- `buf_len`  in  16: page length in read words; valid while `buf_rd_busy` is high.
- `buf_rd_addr`  out  `P_RD_ADDR_WIDTH`: registered read address.
- `buf_rd_dout`  in  `P_RD_DATA_WIDTH`: DPRAM read data.
- `buf_done`  out  1: one-cycle release pulse.
- `dout`  out  `P_RD_DATA_WIDTH`: stream data.
- `dout_valid`  out  1: stream valid.
- `dout_ready`  in  1: stream ready.
- `dout_last`  out  1: marks the final word of the page.
- `pages_read`  out  16: page counter (see Configuration).
- `words_read`  out  32: word counter (see Configuration).

## Operation
- Reset values: `buf_rd_addr` = 0, `buf_done` = 0, `dout` = 0, `dout_valid` = 0, `dout_last` = 0, counters = 0, FSM = S_IDLE, output FIFO empty.
- Effective length `n` = min(`buf_len`, 2^`P_RD_ADDR_WIDTH`). It is latched on leaving S_IDLE.
- FSM states and transitions:
  - S_IDLE: when `buf_rd_busy` = 1, latch `n`. Go to S_READ if `n` > 0, else go to S_DONE.
  - S_READ: issue addresses 0..n−1 in order, at most one per cycle, gated by credit. After issuing address n−1, go to S_DRAIN.
  - S_DRAIN: wait until no reads are in flight and the last word has handshaked (`dout_valid` & `dout_ready` with `dout_last`). Then go to S_DONE.
  - S_DONE: `buf_done` = 1 for exactly this cycle. Go to S_RELEASE.
  - S_RELEASE: wait for `buf_rd_busy` = 0, then go to S_GUARD.
  - S_GUARD: one cycle for the buffer's index swap to settle. Go to S_IDLE.
- Read return path:
  - A shift-register valid pipe of depth `P_RD_LATENCY` tags each issued read.
  - Returned words enter an output FIFO of depth `P_RD_LATENCY`+2. The FIFO output is registered and show-ahead.
- Credit rule: issue only when in_flight + occupancy < `P_RD_LATENCY`+2, where occupancy excludes a word popped in the same cycle. The FIFO never overflows, and no returned word is dropped.
- `dout_last` accompanies the word read from address n−1.
- `dout` is held stable while `dout_valid` is high and `dout_ready` is low.
- `buf_done` is never asserted while `buf_rd_busy` = 0, and is never asserted twice for one page.
- Reset mid-page: the FIFO and pipe are flushed and no `buf_done` is issued. The double buffer shares `rst` and clears its own state.

## Timing
- `buf_rd_busy` first sampled high at cycle T: `buf_rd_addr` = 0 at T+1.
- Data for an address presented at cycle A enters the FIFO at A+`P_RD_LATENCY`. `dout_valid` rises at A+`P_RD_LATENCY`+1, so first `dout_valid` is at T+2+`P_RD_LATENCY` (T+4 at the default).
- With `dout_ready` held high, throughput is one word per cycle with no bubbles.
- Last-word handshake at cycle X: `buf_done` at X+1. With `buf_rd_busy` low at X+2, the FSM is in S_GUARD at X+3 and S_IDLE at X+4. The next page's address 0 is issued no earlier than X+5.
- `n` = 0 page: `buf_done` at T+1.

## Configuration
- `DBUF_PAGE_READER_STATS_EN` defined:
  - `pages_read` increments on each `buf_done`, wrapping at 2^16.
  - `words_read` increments on each stream handshake, saturating at 2^32−1.
  - Both clear on `rst`.
- `DBUF_PAGE_READER_STATS_EN` undefined: both counter outputs are tied to 0, no counter logic is built, and all other behaviour is identical.

## Test plan
- Buffer len 4, data A0..A3, `dout_ready` high → addresses 0,1,2,3 on consecutive cycles from T+1; `dout_valid` T+4..T+7 with A0..A3; `dout_last` on A3 only; one `buf_done` at T+8.
- Buffer len 0 → no `dout_valid`; `buf_done` at T+1; return to S_IDLE after busy clears.
- Buffer len 8, `dout_ready` random at 30% duty → exactly 8 handshakes in address order, no duplicates, FIFO never exceeds 4 entries, `dout` stable while stalled.
- Buffer len 600 → exactly 512 words, last address 511, `dout_last` on word 511.
- Both halves pre-filled, len 3 and len 5 → 3 words plus one `buf_done`, then a gap of at least 4 cycles, then 5 words from the other half plus one `buf_done`.
- `rst` asserted after the 3rd of 8 words → all outputs at reset values the next cycle, no `buf_done`; with the macro defined, `words_read` = 0 after reset and 8 after a clean rerun.
